// File: rtl/vm1_tve_qbus.sv
// vm1_tve_qbus: Q-bus slave front end for the VE1 timer register file.
// Decodes the multiplexed address/data cycle, generates the timer register
// read selects and write strobes, merges byte writes to the limit register
// and produces RPLY.
// Ports:
//   tve_clk, tve_reset        clock, asynchronous active-high reset
//   tve_ena                   timer clock enable, qualifies write strobes
//   qb_ad_in, qb_sync,
//   qb_din, qb_dout, qb_wtbt  bus-side inputs
//   qb_ad_out, qb_ad_oe,
//   qb_rply                   bus-side read data, drive enable, reply
//   tve_dout                  timer read data
//   tve_din                   timer write data
//   tve_{csr,cnt,lim}_oe      timer register read selects
//   tve_{csr,lim}_wr          timer register write strobes
module vm1_tve_qbus #(
    parameter logic [15:0] BASE     = 16'o177706,
    parameter int unsigned RPLY_DLY = 1
) (
    input  logic        tve_clk,
    input  logic        tve_reset,
    input  logic        tve_ena,
    input  logic [15:0] qb_ad_in,
    input  logic        qb_sync,
    input  logic        qb_din,
    input  logic        qb_dout,
    input  logic        qb_wtbt,
    output logic [15:0] qb_ad_out,
    output logic        qb_ad_oe,
    output logic        qb_rply,
    input  logic [15:0] tve_dout,
    output logic [15:0] tve_din,
    output logic        tve_csr_oe,
    output logic        tve_cnt_oe,
    output logic        tve_lim_oe,
    output logic        tve_csr_wr,
    output logic        tve_lim_wr
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_READ, S_MERGE, S_STROBE, S_REPLY, S_DONE
    } state_t;

    localparam logic [15:0] CNT_A = BASE + 16'd2;
    localparam logic [15:0] CSR_A = BASE + 16'd4;
    localparam logic [3:0]  DLY   = 4'(RPLY_DLY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  sel_q, sel_d;      // one-hot {csr, cnt, lim}
    logic        byte_q, byte_d;    // address bit 0: odd byte
    logic        oe_q, oe_d;
    logic        wr_q, wr_d;
    logic        rply_q, rply_d;
    logic        ad_oe_q, ad_oe_d;
    logic [15:0] ad_out_q, ad_out_d;
    logic [15:0] din_q, din_d;      // write data, reused as merge buffer
    logic [2:0]  dec;

    assign dec = {qb_ad_in[15:1] == CSR_A[15:1],
                  qb_ad_in[15:1] == CNT_A[15:1],
                  qb_ad_in[15:1] == BASE[15:1]};

    assign qb_ad_out  = ad_out_q;
    assign qb_ad_oe   = ad_oe_q;
    assign qb_rply    = rply_q;
    assign tve_din    = din_q;
    assign tve_lim_oe = oe_q & sel_q[0];
    assign tve_cnt_oe = oe_q & sel_q[1];
    assign tve_csr_oe = oe_q & sel_q[2];
    assign tve_lim_wr = wr_q & sel_q[0];
    assign tve_csr_wr = wr_q & sel_q[2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        byte_d   = byte_q;
        oe_d     = oe_q;
        wr_d     = wr_q;
        rply_d   = rply_q;
        ad_oe_d  = ad_oe_q;
        ad_out_d = ad_out_q;
        din_d    = din_q;
        case (state_q)
            S_IDLE: begin
                if (qb_sync) begin
                    sel_d   = dec;
                    byte_d  = qb_ad_in[0];
                    state_d = |dec ? S_ADDR : S_DONE;
                end
            end
            S_ADDR: begin
                cnt_d = '0;
                if (!qb_sync) state_d = S_IDLE;
                else if (qb_din && qb_dout) state_d = S_DONE;
                else if (qb_din) state_d = S_READ;
                else if (qb_dout) begin
                    if (sel_q[0] && qb_wtbt) begin
                        state_d = S_MERGE;
                        din_d   = qb_ad_in;
                    end else if (sel_q[0] || (sel_q[2] && !(qb_wtbt && byte_q))) begin
                        state_d = S_STROBE;
                        din_d   = qb_ad_in;
                    end else state_d = S_REPLY;
                end
            end
            S_READ: begin
                if (!qb_sync) state_d = S_IDLE;
                else if (!qb_din) state_d = S_DONE;
                else begin
                    // counter freezes once RPLY is up so it cannot wrap
                    if (!rply_q) cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd0) oe_d = 1'b1;
                    if (cnt_q == 4'd1) begin
                        ad_out_d = tve_dout;
                        ad_oe_d  = 1'b1;
                    end
                    if (cnt_q == DLY + 4'd1) rply_d = 1'b1;
                end
            end
            S_MERGE: begin
                if (!qb_sync) state_d = S_IDLE;
                else if (cnt_q == 4'd0) begin
                    cnt_d = 4'd1;
                    oe_d  = 1'b1;
                end else begin
                    oe_d    = 1'b0;
                    din_d   = byte_q ? {din_q[15:8], tve_dout[7:0]} : {tve_dout[15:8], din_q[7:0]};
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                // once raised, the strobe must see one enabled cycle even if SYNC drops
                if (!wr_q) begin
                    if (!qb_sync) state_d = S_IDLE;
                    else wr_d = 1'b1;
                end else if (tve_ena) begin
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = qb_sync ? S_REPLY : S_IDLE;
                end
            end
            S_REPLY: begin
                if (!qb_sync) state_d = S_IDLE;
                else if (!qb_dout) state_d = S_DONE;
                else if (!rply_q) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == DLY - 4'd1) rply_d = 1'b1;
                end
            end
            S_DONE: begin
                if (!qb_sync) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // IDLE and DONE are fully passive
        if (state_d == S_IDLE || state_d == S_DONE) begin
            oe_d     = 1'b0;
            wr_d     = 1'b0;
            rply_d   = 1'b0;
            ad_oe_d  = 1'b0;
            ad_out_d = '0;
            din_d    = '0;
        end
    end

    always_ff @(posedge tve_clk or posedge tve_reset) begin
        if (tve_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            byte_q   <= 1'b0;
            oe_q     <= 1'b0;
            wr_q     <= 1'b0;
            rply_q   <= 1'b0;
            ad_oe_q  <= 1'b0;
            ad_out_q <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            byte_q   <= byte_d;
            oe_q     <= oe_d;
            wr_q     <= wr_d;
            rply_q   <= rply_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
            din_q    <= din_d;
        end
    end
endmodule

// File: tb/tb_vm1_tve_qbus.sv
// tb_vm1_tve_qbus: self-checking bench for vm1_tve_qbus with a timer register stub.
module tb_vm1_tve_qbus;
    localparam int D = 1;

    logic        tve_clk = 1'b0;
    logic        tve_reset, tve_ena;
    logic [15:0] qb_ad_in;
    logic        qb_sync, qb_din, qb_dout, qb_wtbt;
    logic [15:0] qb_ad_out, tve_dout, tve_din;
    logic        qb_ad_oe, qb_rply;
    logic        tve_csr_oe, tve_cnt_oe, tve_lim_oe, tve_csr_wr, tve_lim_wr;

    always #5 tve_clk = ~tve_clk;

    vm1_tve_qbus #(.RPLY_DLY(D)) dut (
        .tve_clk(tve_clk), .tve_reset(tve_reset), .tve_ena(tve_ena),
        .qb_ad_in(qb_ad_in), .qb_sync(qb_sync), .qb_din(qb_din),
        .qb_dout(qb_dout), .qb_wtbt(qb_wtbt), .qb_ad_out(qb_ad_out),
        .qb_ad_oe(qb_ad_oe), .qb_rply(qb_rply), .tve_dout(tve_dout),
        .tve_din(tve_din), .tve_csr_oe(tve_csr_oe), .tve_cnt_oe(tve_cnt_oe),
        .tve_lim_oe(tve_lim_oe), .tve_csr_wr(tve_csr_wr), .tve_lim_wr(tve_lim_wr)
    );

    // timer register stub
    logic [15:0] m_lim, m_cnt, m_csr, pl_lim, pl_cnt, pl_csr;
    logic        pl;
    always @(posedge tve_clk) begin
        if (pl) begin
            m_lim <= pl_lim;
            m_cnt <= pl_cnt;
            m_csr <= pl_csr;
        end else if (tve_ena) begin
            if (tve_lim_wr) m_lim <= tve_din;
            if (tve_csr_wr) m_csr <= tve_din;
        end
    end
    assign tve_dout = tve_lim_oe ? m_lim : tve_cnt_oe ? m_cnt : tve_csr_oe ? m_csr : 16'h0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tve_clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{qb_ad_out, qb_ad_oe, qb_rply, tve_din, tve_csr_oe, tve_cnt_oe,
                 tve_lim_oe, tve_csr_wr, tve_lim_wr};
    endfunction

    task automatic preload(input logic [15:0] l, input logic [15:0] c, input logic [15:0] s);
        pl_lim = l; pl_cnt = c; pl_csr = s; pl = 1'b1;
        tick();
        pl = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data,
                            output logic [2:0] oe1, output logic aoe, output int rk,
                            output logic rel);
        data = '0; oe1 = '0; aoe = 1'b0; rk = -1;
        qb_ad_in = addr; qb_sync = 1'b1;
        tick();
        qb_ad_in = 16'h0; qb_din = 1'b1;
        tick();
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) oe1 = {tve_csr_oe, tve_cnt_oe, tve_lim_oe};
            if (qb_rply) begin
                rk = k; data = qb_ad_out; aoe = qb_ad_oe;
                break;
            end
        end
        qb_din = 1'b0;
        tick();
        rel = ~any_out();
        qb_sync = 1'b0;
        tick();
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data, input logic wtbt,
                             input int stall, input logic rnd, output int rk, output int fw,
                             output int wr_cyc, output int en_l, output int en_c,
                             output logic [2:0] oe_seen, output logic [15:0] din_wr,
                             output logic rel);
        int low = 0;
        rk = -1; fw = -1; wr_cyc = 0; en_l = 0; en_c = 0; oe_seen = '0; din_wr = '0;
        tve_ena = 1'b1;
        qb_ad_in = addr; qb_sync = 1'b1;
        tick();
        qb_ad_in = data; qb_wtbt = wtbt; qb_dout = 1'b1;
        tick();
        for (int k = 0; k <= 40; k++) begin
            oe_seen |= {tve_csr_oe, tve_cnt_oe, tve_lim_oe};
            if (tve_lim_wr || tve_csr_wr) begin
                if (fw < 0) fw = k;
                wr_cyc++;
                din_wr = tve_din;
            end
            if (qb_rply) begin
                rk = k;
                break;
            end
            if (rnd) tve_ena = 1'($urandom_range(0, 1));
            else if ((tve_lim_wr || tve_csr_wr) && low < stall) begin
                tve_ena = 1'b0;
                low++;
            end else tve_ena = 1'b1;
            en_l += int'(tve_lim_wr & tve_ena);
            en_c += int'(tve_csr_wr & tve_ena);
            tick();
        end
        tve_ena = 1'b1; qb_dout = 1'b0;
        tick();
        rel = ~any_out();
        qb_sync = 1'b0; qb_wtbt = 1'b0;
        tick();
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic        wtbt;
        logic [15:0] data;
        logic [2:0]  exp_oe;
        logic [15:0] exp_val;
        int          exp_lw;
        int          exp_cw;
        int          exp_rply;
        int          exp_fw;
    } vec_t;

    vec_t vt[14];

    initial begin
        logic [15:0] rd, dw, ref_lim, ref_csr, ref_cnt;
        logic [2:0]  oe1, oes;
        logic        aoe, rel, any;
        int          rk, fw, wc, el, ec;

        vt[0]  = '{1'b0, 16'o177712, 1'b0, 16'h0000, 3'b100, 16'hFF94, 0, 0, 2 + D, -1};
        vt[1]  = '{1'b0, 16'o177706, 1'b0, 16'h0000, 3'b001, 16'hABCD, 0, 0, 2 + D, -1};
        vt[2]  = '{1'b0, 16'o177710, 1'b0, 16'h0000, 3'b010, 16'h0042, 0, 0, 2 + D, -1};
        vt[3]  = '{1'b1, 16'o177707, 1'b1, 16'h5600, 3'b001, 16'h56CD, 1, 0, 4 + D, 3};
        vt[4]  = '{1'b0, 16'o177706, 1'b0, 16'h0000, 3'b001, 16'h56CD, 0, 0, 2 + D, -1};
        vt[5]  = '{1'b1, 16'o177706, 1'b1, 16'h00EF, 3'b001, 16'h56EF, 1, 0, 4 + D, 3};
        vt[6]  = '{1'b1, 16'o177706, 1'b0, 16'h1234, 3'b000, 16'h1234, 1, 0, 2 + D, 1};
        vt[7]  = '{1'b0, 16'o177706, 1'b0, 16'h0000, 3'b001, 16'h1234, 0, 0, 2 + D, -1};
        vt[8]  = '{1'b1, 16'o177710, 1'b0, 16'hFFFF, 3'b000, 16'h0000, 0, 0, -1, -1};
        vt[9]  = '{1'b1, 16'o177713, 1'b1, 16'h1200, 3'b000, 16'h0000, 0, 0, -1, -1};
        vt[10] = '{1'b1, 16'o177712, 1'b1, 16'h0041, 3'b000, 16'h0041, 0, 1, 2 + D, 1};
        vt[11] = '{1'b1, 16'o177712, 1'b0, 16'hBEEF, 3'b000, 16'hBEEF, 0, 1, 2 + D, 1};
        vt[12] = '{1'b0, 16'o177712, 1'b0, 16'h0000, 3'b100, 16'hBEEF, 0, 0, 2 + D, -1};
        vt[13] = '{1'b0, 16'o177710, 1'b0, 16'h0000, 3'b010, 16'h0042, 0, 0, 2 + D, -1};

        tve_reset = 1'b1; tve_ena = 1'b1; qb_ad_in = '0; qb_sync = 1'b0;
        qb_din = 1'b0; qb_dout = 1'b0; qb_wtbt = 1'b0; pl = 1'b0;
        pl_lim = '0; pl_cnt = '0; pl_csr = '0;
        tick();
        tick();
        chk("reset_outputs", any_out(), 1'b0);
        tve_reset = 1'b0;
        preload(16'hABCD, 16'h0042, 16'hFF94);

        foreach (vt[i]) begin
            if (!vt[i].wr) begin
                bus_read(vt[i].addr, rd, oe1, aoe, rk, rel);
                chk($sformatf("rd%0d_oe", i), oe1, vt[i].exp_oe);
                chk($sformatf("rd%0d_data", i), rd, vt[i].exp_val);
                chk($sformatf("rd%0d_ad_oe", i), aoe, 1'b1);
                chk($sformatf("rd%0d_rply_edge", i), rk, vt[i].exp_rply);
                chk($sformatf("rd%0d_release", i), rel, 1'b1);
            end else begin
                bus_write(vt[i].addr, vt[i].data, vt[i].wtbt, 0, 1'b0, rk, fw, wc, el, ec, oes, dw, rel);
                chk($sformatf("wr%0d_oe", i), oes, vt[i].exp_oe);
                chk($sformatf("wr%0d_lim_wr", i), el, vt[i].exp_lw);
                chk($sformatf("wr%0d_csr_wr", i), ec, vt[i].exp_cw);
                chk($sformatf("wr%0d_first_wr", i), fw, vt[i].exp_fw);
                chk($sformatf("wr%0d_release", i), rel, 1'b1);
                if (vt[i].exp_rply < 0) chk($sformatf("wr%0d_rply_seen", i), rk >= 0, 1'b1);
                else begin
                    chk($sformatf("wr%0d_rply_edge", i), rk, vt[i].exp_rply);
                    chk($sformatf("wr%0d_din", i), dw, vt[i].exp_val);
                end
            end
        end

        // strobe stretched by three disabled cycles
        bus_write(16'o177712, 16'h00AA, 1'b0, 3, 1'b0, rk, fw, wc, el, ec, oes, dw, rel);
        chk("stall_wr_cycles", wc, 4);
        chk("stall_en_cycles", ec, 1);
        chk("stall_rply_edge", rk, 2 + D + 3);
        chk("stall_din", dw, 16'h00AA);
        chk("stall_csr", m_csr, 16'h00AA);

        // addresses just outside the register window stay passive
        foreach (vt[i]) begin
            if (i < 3) begin
                qb_ad_in = (i == 0) ? 16'o177700 : (i == 1) ? 16'o177714 : 16'o177704;
                qb_sync = 1'b1;
                tick();
                qb_din = (i != 1); qb_dout = (i == 1);
                any = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    tick();
                    any |= any_out();
                end
                chk($sformatf("nomatch%0d_passive", i), any, 1'b0);
                qb_din = 1'b0; qb_dout = 1'b0; qb_sync = 1'b0;
                tick();
            end
        end

        // SYNC drops during the limit merge: no strobe, no reply
        preload(16'h7777, 16'h0042, 16'h00AA);
        qb_ad_in = 16'o177707; qb_sync = 1'b1;
        tick();
        qb_ad_in = 16'h1100; qb_wtbt = 1'b1; qb_dout = 1'b1;
        tick();
        tick();
        chk("merge_lim_oe", tve_lim_oe, 1'b1);
        qb_sync = 1'b0;
        any = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            any |= any_out();
        end
        chk("merge_abort_passive", any, 1'b0);
        chk("merge_abort_lim", m_lim, 16'h7777);
        qb_dout = 1'b0; qb_wtbt = 1'b0;
        tick();

        // DIN and DOUT together: no reply at all
        qb_ad_in = 16'o177706; qb_sync = 1'b1;
        tick();
        qb_din = 1'b1; qb_dout = 1'b1;
        any = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            any |= any_out();
        end
        chk("proto_err_passive", any, 1'b0);
        qb_din = 1'b0; qb_dout = 1'b0; qb_sync = 1'b0;
        tick();

        // reset in the middle of a read
        qb_ad_in = 16'o177712; qb_sync = 1'b1;
        tick();
        qb_din = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("rst_read_active", qb_rply, 1'b1);
        tve_reset = 1'b1;
        tick();
        chk("rst_read_cleared", any_out(), 1'b0);
        qb_din = 1'b0; qb_sync = 1'b0;
        tick();
        tve_reset = 1'b0;
        tick();
        bus_read(16'o177712, rd, oe1, aoe, rk, rel);
        chk("rst_recover_data", rd, 16'h00AA);
        chk("rst_recover_rply", rk, 2 + D);

        // random traffic against a register-level reference
        ref_lim = 16'h2468; ref_cnt = 16'h0042; ref_csr = 16'h0011;
        preload(ref_lim, ref_cnt, ref_csr);
        for (int n = 0; n < 40; n++) begin
            int r;
            logic w, bt, odd;
            logic [15:0] d, exp_rd;
            r = int'($urandom_range(0, 2));
            w = 1'($urandom_range(0, 1));
            bt = w & 1'($urandom_range(0, 1));
            odd = bt & 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if (!w) begin
                exp_rd = (r == 0) ? ref_lim : (r == 1) ? ref_cnt : ref_csr;
                bus_read(16'o177706 + 16'(2 * r), rd, oe1, aoe, rk, rel);
                chk($sformatf("rnd%0d_rd_data", n), rd, exp_rd);
                chk($sformatf("rnd%0d_rd_rply", n), rk, 2 + D);
            end else begin
                int exp_l, exp_c;
                exp_l = (r == 0) ? 1 : 0;
                exp_c = (r == 2 && !(bt && odd)) ? 1 : 0;
                if (r == 0) ref_lim = !bt ? d : odd ? {d[15:8], ref_lim[7:0]} : {ref_lim[15:8], d[7:0]};
                if (exp_c == 1) ref_csr = d;
                bus_write(16'o177706 + 16'(2 * r) + 16'(odd), d, bt, 0, 1'b1, rk, fw, wc, el, ec, oes, dw, rel);
                chk($sformatf("rnd%0d_en_lim", n), el, exp_l);
                chk($sformatf("rnd%0d_en_csr", n), ec, exp_c);
                chk($sformatf("rnd%0d_wr_rply", n), rk >= 0, 1'b1);
                chk($sformatf("rnd%0d_lim", n), m_lim, ref_lim);
                chk($sformatf("rnd%0d_csr", n), m_csr, ref_csr);
            end
            chk($sformatf("rnd%0d_release", n), rel, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
